// File: rtl/mod_exp_host_if_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_host_if_if
// Purpose  : Host-side word-stream bus for the mod_exp host interface.
//            The write channel carries operand words into the block. The read
//            channel returns the result words. Both channels use a
//            valid/ready handshake.
// Ports    : none. The signal bundle is accessed through two modports:
//            master - host side (drives wr_*, cfg_m_size, rd_ready)
//            slave  - mod_exp_host_if side (drives wr_ready, rd_*)
// Revision : 1.0  initial release
// ============================================================================
interface mod_exp_host_if_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [11:0] cfg_m_size;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;

  modport master (
    output wr_valid, wr_data, cfg_m_size, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, cfg_m_size, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );
endinterface
`default_nettype wire

// File: rtl/mod_exp_host_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_host_if
// Purpose  : Host-side driver for one mod_exp engine. The block collects the
//            operands a, exp and m as 32-bit words, least-significant word
//            first. It checks m against m_size and derives
//            r_red = 2^m_size - m. It then fires the engine with a one-cycle
//            start pulse, waits for done under a timeout, and streams y back
//            out as 32-bit words.
// Ports    : clk, rst_n        clock and async active-low reset
//            bus (slave)       wr_valid/wr_ready/wr_data/cfg_m_size,
//                              rd_valid/rd_ready/rd_data/rd_last
//            busy              job in flight (first word .. last result word)
//            err_p, err_code   one-cycle error pulse. The code is
//                              1: m==0, 2: bad m_size, 3: timeout.
//            me_*              engine operands, start pulse, result, done
// Revision : 1.0  initial release
// ============================================================================
module mod_exp_host_if #(
  parameter int NBITS       = 256,      // operand width, multiple of 32
  parameter int TIMEOUT_CYC = 1048576   // max wait cycles for done
) (
  input  logic             clk,
  input  logic             rst_n,
  mod_exp_host_if_if.slave bus,
  output logic             busy,
  output logic             err_p,
  output logic [1:0]       err_code,
  output logic             me_enable_p,
  output logic [NBITS-1:0] me_a,
  output logic [NBITS-1:0] me_exp,
  output logic [NBITS-1:0] me_m,
  output logic [11:0]      me_m_size,
  output logic [NBITS-1:0] me_r_red,
  input  logic [NBITS-1:0] me_y,
  input  logic             me_done_irq_p
);

  localparam int NW = NBITS / 32;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IW-1:0] LAST_WORD = IW'(NW - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [11:0]   MSZ_MAX   = 12'(NBITS);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_M_ZERO  = 2'd1;
  localparam logic [1:0] ERR_M_SIZE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              live_q;               // low only until the first clock after reset
  logic [1:0]        op_q, op_d;           // operand being loaded: 0 a, 1 exp, 2 m
  logic [IW-1:0]     wi_q, wi_d;           // word index within operand
  logic [NBITS-1:0]  a_q, a_d;
  logic [NBITS-1:0]  exp_q, exp_d;
  logic [NBITS-1:0]  m_q, m_d;
  logic [11:0]       msz_q, msz_d;
  logic [NBITS-1:0]  rred_q, rred_d;
  logic [NBITS-1:0]  res_q, res_d;
  logic [IW-1:0]     ri_q, ri_d;           // result word index
  logic [TW-1:0]     to_q, to_d;           // cycles spent in WAIT
  logic              busy_q, busy_d;
  logic              errp_q, errp_d;
  logic [1:0]        errc_q, errc_d;

  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_rd_valid;
  logic              w_rd_last;
  logic [31:0]       w_rd_data;
  logic              w_m_zero;
  logic              w_size_bad;
  logic [NBITS-1:0]  w_rred;

  // Operand checks, evaluated on the registered operands during CHECK.
  assign w_m_zero   = (m_q == '0);
  assign w_size_bad = (msz_q == 12'd0) || (msz_q > MSZ_MAX) || ((m_q >> msz_q) != '0);

  // (2^m_size - m) mod 2^NBITS. For m_size == NBITS the shifted one falls off
  // the top and becomes 0, so 0 - m wraps to 2^NBITS - m. This gives the same
  // result as the NBITS+1 wide form after truncation.
  assign w_rred = (NBITS'(1) << msz_q) - m_q;

  assign w_wr_ready = live_q && (state_q == S_LOAD);
  assign w_wr_fire  = bus.wr_valid && w_wr_ready;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wi_d        = wi_q;
    a_d         = a_q;
    exp_d       = exp_q;
    m_d         = m_q;
    msz_d       = msz_q;
    rred_d      = rred_q;
    res_d       = res_q;
    ri_d        = ri_q;
    to_d        = to_q;
    busy_d      = busy_q;
    errp_d      = 1'b0;
    errc_d      = errc_q;
    me_enable_p = 1'b0;
    w_rd_valid  = 1'b0;
    w_rd_last   = 1'b0;
    w_rd_data   = '0;

    case (state_q)
      S_LOAD: begin
        if (w_wr_fire) begin
          busy_d = 1'b1;
          errc_d = ERR_NONE;
          case (op_q)
            2'd0:    a_d[{wi_q, 5'b0} +: 32]   = bus.wr_data;
            2'd1:    exp_d[{wi_q, 5'b0} +: 32] = bus.wr_data;
            default: m_d[{wi_q, 5'b0} +: 32]   = bus.wr_data;
          endcase
          if (wi_q == LAST_WORD) begin
            wi_d = '0;
            if (op_q == 2'd2) begin
              op_d    = 2'd0;
              msz_d   = bus.cfg_m_size;
              state_d = S_CHECK;
            end else begin
              op_d = op_q + 2'd1;
            end
          end else begin
            wi_d = wi_q + IW'(1);
          end
        end
      end

      S_CHECK: begin
        if (w_m_zero) begin
          errp_d  = 1'b1;
          errc_d  = ERR_M_ZERO;
          busy_d  = 1'b0;
          state_d = S_LOAD;
        end else if (w_size_bad) begin
          errp_d  = 1'b1;
          errc_d  = ERR_M_SIZE;
          busy_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          rred_d  = w_rred;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        me_enable_p = 1'b1;
        to_d        = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        // Done is checked before the timeout, so a done arriving on the
        // last allowed cycle still delivers its result.
        if (me_done_irq_p) begin
          res_d   = me_y;
          ri_d    = '0;
          state_d = S_OUT;
        end else if (to_q == TO_LAST) begin
          errp_d  = 1'b1;
          errc_d  = ERR_TIMEOUT;
          busy_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      S_OUT: begin
        w_rd_valid = 1'b1;
        w_rd_data  = res_q[{ri_q, 5'b0} +: 32];
        w_rd_last  = (ri_q == LAST_WORD);
        if (bus.rd_ready) begin
          if (ri_q == LAST_WORD) begin
            ri_d    = '0;
            busy_d  = 1'b0;
            state_d = S_LOAD;
          end else begin
            ri_d = ri_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      live_q  <= 1'b0;
      op_q    <= 2'd0;
      wi_q    <= '0;
      a_q     <= '0;
      exp_q   <= '0;
      m_q     <= '0;
      msz_q   <= 12'd0;
      rred_q  <= '0;
      res_q   <= '0;
      ri_q    <= '0;
      to_q    <= '0;
      busy_q  <= 1'b0;
      errp_q  <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      op_q    <= op_d;
      wi_q    <= wi_d;
      a_q     <= a_d;
      exp_q   <= exp_d;
      m_q     <= m_d;
      msz_q   <= msz_d;
      rred_q  <= rred_d;
      res_q   <= res_d;
      ri_q    <= ri_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      errp_q  <= errp_d;
      errc_q  <= errc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_data  = w_rd_data;
  assign bus.rd_last  = w_rd_last;

  assign busy      = busy_q;
  assign err_p     = errp_q;
  assign err_code  = errc_q;
  assign me_a      = a_q;
  assign me_exp    = exp_q;
  assign me_m      = m_q;
  assign me_m_size = msz_q;
  assign me_r_red  = rred_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_host_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mod_exp_host_if
// Purpose  : Self-checking bench for mod_exp_host_if. It uses a vector table,
//            randomized jobs checked against a reference model, and a
//            reset-during-WAIT sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod_exp_host_if;
  localparam int NBITS = 256;
  localparam int NW    = NBITS / 32;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy, err_p, me_enable_p, me_done_irq_p;
  logic [1:0]       err_code;
  logic [NBITS-1:0] me_a, me_exp, me_m, me_r_red, me_y;
  logic [11:0]      me_m_size;

  mod_exp_host_if_if bus ();

  mod_exp_host_if #(.NBITS(NBITS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .err_p(err_p), .err_code(err_code),
    .me_enable_p(me_enable_p), .me_a(me_a), .me_exp(me_exp), .me_m(me_m),
    .me_m_size(me_m_size), .me_r_red(me_r_red), .me_y(me_y),
    .me_done_irq_p(me_done_irq_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NBITS-1:0] a, e, m;
    logic [11:0]      msz;
    logic [NBITS-1:0] y;        // value the engine model returns
    int               dly;      // cycles from start pulse to done (0: never)
    int               rdp;      // rd_ready pattern: 0 always, 1 toggle 1,0,0, 2 random
    int               rst;      // >0: reset this many cycles into WAIT
    int               exp_err;
    logic [NBITS-1:0] exp_rred;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] err_hold = 2'd0;   // err_code the DUT must still be holding

  task automatic chkw(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [NBITS-1:0] a, e, m, input int msz,
                              input logic [NBITS-1:0] y, input int dly, rdp, rst,
                              input int exp_err, input logic [NBITS-1:0] exp_rred);
    vec_t v;
    v.a = a; v.e = e; v.m = m; v.msz = 12'(msz); v.y = y;
    v.dly = dly; v.rdp = rdp; v.rst = rst; v.exp_err = exp_err; v.exp_rred = exp_rred;
    return v;
  endfunction

  function automatic logic [NBITS-1:0] rnd256();
    logic [NBITS-1:0] r;
    for (int i = 0; i < NW; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: the error rules and 2^m_size - m, computed as plain
  // arithmetic on an NBITS+1 wide value.
  function automatic void model(input logic [NBITS-1:0] m, input logic [11:0] msz,
                                output int err, output logic [NBITS-1:0] rred);
    logic [NBITS:0] pw;
    rred = '0;
    if (m == '0) err = 1;
    else if (int'(msz) == 0 || int'(msz) > NBITS) err = 2;
    else begin
      pw = (NBITS+1)'(1) << msz;
      if ({1'b0, m} >= pw) err = 2;
      else begin
        err  = 0;
        pw   = pw - {1'b0, m};
        rred = pw[NBITS-1:0];
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    chkw({tag, "_ctrl"}, NBITS'({bus.wr_ready, bus.rd_valid, bus.rd_last, busy, err_p, err_code, me_enable_p}), '0);
    chkw({tag, "_data"}, me_a | me_exp | me_m | me_r_red | NBITS'(bus.rd_data) | NBITS'(me_m_size), '0);
  endtask

  task automatic run_job(input vec_t v);
    logic [NBITS-1:0] ops [3];
    int  acc, guard, idx, cyc;
    logic hs, rr;
    ops[0] = v.a; ops[1] = v.e; ops[2] = v.m;

    guard = 0;
    while (!bus.wr_ready && guard < 200) begin step(); guard++; end
    chkb("wr_ready_idle", bus.wr_ready, 1'b1);
    chkw("err_code_held", NBITS'(err_code), NBITS'(err_hold));
    chkb("busy_idle", busy, 1'b0);

    // Load phase with random valid gaps; m_size is junk except on the last word.
    acc = 0; guard = 0;
    while (acc < 3*NW && guard < 1000) begin
      bus.wr_valid   = ($urandom_range(0, 3) != 0);
      bus.wr_data    = ops[acc / NW][32*(acc % NW) +: 32];
      bus.cfg_m_size = (acc == 3*NW-1) ? v.msz : 12'($urandom);
      hs = bus.wr_valid && bus.wr_ready;
      step(); guard++;
      if (hs) begin
        acc++;
        if (acc == 1) begin
          chkb("busy_after_first_word", busy, 1'b1);
          chkw("err_code_cleared", NBITS'(err_code), '0);
          err_hold = 2'd0;
        end
      end
    end
    bus.wr_valid = 1'b0;
    chkw("load_budget", NBITS'(acc), NBITS'(3*NW));

    // CHECK cycle (T+1)
    chkb("wr_ready_in_check", bus.wr_ready, 1'b0);
    chkb("no_enable_in_check", me_enable_p, 1'b0);
    step();

    if (v.exp_err == 1 || v.exp_err == 2) begin
      chkb("err_p", err_p, 1'b1);
      chkw("err_code", NBITS'(err_code), NBITS'(v.exp_err));
      chkb("busy_after_err", busy, 1'b0);
      chkb("no_enable_on_err", me_enable_p, 1'b0);
      chkb("wr_ready_after_err", bus.wr_ready, 1'b1);
      err_hold = 2'(v.exp_err);
      step();
      chkb("err_p_one_cycle", err_p, 1'b0);
      chkb("no_enable_after_err", me_enable_p, 1'b0);
      return;
    end

    // LAUNCH cycle (T+2)
    chkb("enable_at_T2", me_enable_p, 1'b1);
    chkw("r_red", me_r_red, v.exp_rred);
    chkw("me_a", me_a, v.a);
    chkw("me_exp", me_exp, v.e);
    chkw("me_m", me_m, v.m);
    chkw("me_m_size", NBITS'(me_m_size), NBITS'(v.msz));
    step();
    chkb("enable_single_pulse", me_enable_p, 1'b0);
    chkb("wr_ready_in_wait", bus.wr_ready, 1'b0);

    if (v.rst > 0) begin
      repeat (v.rst) step();
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_in_wait");
      me_done_irq_p = 1'b1; me_y = v.y;
      step();
      me_done_irq_p = 1'b0;
      rst_n = 1'b1;
      chkb("wr_ready_low_at_release", bus.wr_ready, 1'b0);
      step();
      chkb("wr_ready_after_release", bus.wr_ready, 1'b1);
      me_done_irq_p = 1'b1;
      step();
      me_done_irq_p = 1'b0;
      step();
      chkb("stale_done_no_rd_valid", bus.rd_valid, 1'b0);
      chkb("stale_done_no_busy", busy, 1'b0);
      chkb("stale_done_no_err", err_p, 1'b0);
      err_hold = 2'd0;
      return;
    end

    if (v.dly == 0) begin
      cyc = 0;
      while (!err_p && cyc < TO + 10) begin step(); cyc++; end
      chkw("timeout_cycles", NBITS'(cyc), NBITS'(TO));
      chkw("timeout_code", NBITS'(err_code), NBITS'(3));
      chkb("busy_after_timeout", busy, 1'b0);
      chkb("no_rd_after_timeout", bus.rd_valid, 1'b0);
      err_hold = 2'd3;
      step();
      chkb("timeout_err_p_one_cycle", err_p, 1'b0);
      return;
    end

    // Engine answers dly cycles after the start pulse.
    repeat (v.dly - 1) step();
    chkw("operands_stable", me_a ^ v.a | me_exp ^ v.e | me_m ^ v.m | me_r_red ^ v.exp_rred, '0);
    me_done_irq_p = 1'b1; me_y = v.y;
    step();
    me_done_irq_p = 1'b0; me_y = rnd256();
    chkb("rd_valid_after_done", bus.rd_valid, 1'b1);
    chkb("no_err_at_out", err_p, 1'b0);

    idx = 0; guard = 0;
    while (idx < NW && guard < 200) begin
      case (v.rdp)
        0:       rr = 1'b1;
        1:       rr = (guard % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.rd_ready = rr;
      chkb("rd_valid", bus.rd_valid, 1'b1);
      chkw("rd_data", NBITS'(bus.rd_data), NBITS'(v.y[32*idx +: 32]));
      chkb("rd_last", bus.rd_last, idx == NW-1);
      chkb("busy_during_out", busy, 1'b1);
      if (!bus.rd_valid) break;
      step(); guard++;
      if (rr) idx++;
    end
    bus.rd_ready = 1'b0;
    chkw("read_words", NBITS'(idx), NBITS'(NW));
    chkb("rd_valid_after_last", bus.rd_valid, 1'b0);
    chkb("busy_after_last", busy, 1'b0);
  endtask

  vec_t tbl [11];
  localparam logic [NBITS-1:0] BIG_M = (NBITS'(1) << 255) + NBITS'(1);
  localparam logic [NBITS-1:0] Y_PAT = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

  initial begin
    vec_t v;
    int   e;
    logic [NBITS-1:0] r;

    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.cfg_m_size = '0; bus.rd_ready = 1'b0;
    me_y = '0; me_done_irq_p = 1'b0;

    //           a    e    m      msz  y      dly rdp rst err rred
    tbl[0]  = mk(11,  8,   5,     12,  1,     20, 0,  0,  0,  4091);
    tbl[1]  = mk(11,  8,   5,     12,  1,     20, 1,  0,  0,  4091);
    tbl[2]  = mk(11,  8,   0,     12,  1,     20, 0,  0,  1,  0);
    tbl[3]  = mk(11,  8,   5,     12,  Y_PAT, 3,  2,  0,  0,  4091);
    tbl[4]  = mk(11,  8,   5000,  12,  1,     20, 0,  0,  2,  0);
    tbl[5]  = mk(11,  8,   5,     257, 1,     20, 0,  0,  2,  0);
    tbl[6]  = mk(7,   3,   BIG_M, 256, Y_PAT, 5,  1,  0,  0,  (NBITS'(1) << 255) - NBITS'(1));
    tbl[7]  = mk(11,  8,   5,     0,   1,     20, 0,  0,  2,  0);
    tbl[8]  = mk(11,  8,   5,     12,  1,     0,  0,  0,  3,  4091);
    tbl[9]  = mk(11,  8,   5,     12,  Y_PAT, 64, 0,  0,  0,  4091);
    tbl[10] = mk(2,   9,   4096,  13,  4,     1,  2,  0,  0,  4096);

    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chkb("wr_ready_before_first_clock", bus.wr_ready, 1'b0);
    step();
    chkb("wr_ready_after_first_clock", bus.wr_ready, 1'b1);

    for (int i = 0; i < 11; i++) run_job(tbl[i]);

    // Randomized jobs against the reference model.
    for (int i = 0; i < 8; i++) begin
      v.a = rnd256(); v.e = rnd256(); v.m = rnd256(); v.y = rnd256();
      v.msz = 12'($urandom_range(1, NBITS));
      case ($urandom_range(0, 4))
        0, 1: if (int'(v.msz) < NBITS) v.m = v.m & ((NBITS'(1) << v.msz) - NBITS'(1));
        2:    v.m = '0;
        3:    v.msz = 12'($urandom_range(NBITS + 1, 4095));
        default: ;
      endcase
      model(v.m, v.msz, e, r);
      v.exp_err = e; v.exp_rred = r;
      v.dly = $urandom_range(1, 40); v.rdp = 2; v.rst = 0;
      run_job(v);
    end

    // Reset ten cycles into WAIT, then a fresh job.
    v = tbl[0]; v.dly = 0; v.rst = 10;
    run_job(v);
    run_job(tbl[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
